// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, bit-reverse helper and port-width helpers for the FFT sequencer
package fft_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, LOAD} state_e;
    function automatic int stage_w(input int log2n);
        return $clog2(log2n);
    endfunction
    function automatic int tw_w(input int log2n);
        return log2n - 1;
    endfunction
    // reverses the low w bits of x; bits above w come back zero
    function automatic logic [9:0] bitrev(input logic [9:0] x, input int w);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r = {r[8:0], 1'(x >> i)};
        return r;
    endfunction
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: DEPTH-cycle shift of {valid, addr_a, addr_b} that turns a butterfly read into its write-back
//   clk, clr_n (async active-low clear of every stage)
//   rd_valid/rd_a/rd_b in, wr_valid/wr_a/wr_b out DEPTH cycles later
module fft_wb_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_a,
    input  logic [AW-1:0] rd_b,
    output logic          wr_valid,
    output logic [AW-1:0] wr_a,
    output logic [AW-1:0] wr_b
);
    localparam int W = 2 * AW + 1;
    localparam int SW = DEPTH * W;
    logic [SW-1:0] sr;
    // newest entry in the low W bits, oldest falls off the top
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) sr <= '0;
        else sr <= SW'({sr, rd_valid, rd_a, rd_b});
    end
    assign {wr_valid, wr_a, wr_b} = sr[SW-1 -: W];
endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: address/stage sequencer for one in-place radix-2 DIT FFT of N = 2**LOG2N points
//   clk, clr_n (async active-low reset), start (sampled in IDLE only), halt (freezes issue in RUN)
//   busy, done (one-cycle pulse), rd_valid/addr_a/addr_b/tw_idx/stage (one butterfly per cycle)
//   wr_valid/wr_addr_a/wr_addr_b (the issue stream delayed by BF_LAT for write-back)
//   FFT_BITREV_EN: adds an N-cycle LOAD phase before RUN with ld_valid/ld_addr (bit-reversed order)
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 2
) (
    input  logic                          clk,
    input  logic                          clr_n,
    input  logic                          start,
    input  logic                          halt,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_valid,
    output logic [LOG2N-1:0]              addr_a,
    output logic [LOG2N-1:0]              addr_b,
    output logic [tw_w(LOG2N)-1:0]        tw_idx,
    output logic [stage_w(LOG2N)-1:0]     stage,
    output logic                          wr_valid,
    output logic [LOG2N-1:0]              wr_addr_a,
    output logic [LOG2N-1:0]              wr_addr_b
`ifdef FFT_BITREV_EN
    ,
    output logic                          ld_valid,
    output logic [LOG2N-1:0]              ld_addr
`endif
);
    localparam int JW = LOG2N - 1;
    localparam int TW = tw_w(LOG2N);
    localparam int SW = stage_w(LOG2N);
    localparam int DW = BF_LAT > 1 ? $clog2(BF_LAT) : 1;
`ifdef FFT_BITREV_EN
    localparam state_e FIRST = LOAD;
    logic [LOG2N-1:0] l, l_nxt;
`else
    localparam state_e FIRST = RUN;
`endif
    state_e state, state_nxt;
    logic [SW-1:0] s, s_nxt;
    logic [JW-1:0] j, j_nxt;
    logic [DW-1:0] d, d_nxt;
    logic [LOG2N-1:0] span, pos, grp, a_nxt, b_nxt;
    logic [TW-1:0] tw_nxt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            s <= '0;
            j <= '0;
            d <= '0;
`ifdef FFT_BITREV_EN
            l <= '0;
`endif
        end else begin
            state <= state_nxt;
            s <= s_nxt;
            j <= j_nxt;
            d <= d_nxt;
`ifdef FFT_BITREV_EN
            l <= l_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt = s;
        j_nxt = j;
        d_nxt = '0;
`ifdef FFT_BITREV_EN
        l_nxt = l;
`endif
        case (state)
            IDLE: if (start) begin
                state_nxt = FIRST;
                s_nxt = '0;
                j_nxt = '0;
            end
`ifdef FFT_BITREV_EN
            LOAD: if (!halt) begin
                l_nxt = l + LOG2N'(1);
                state_nxt = l == '1 ? RUN : LOAD;
            end
`endif
            // j wraps naturally at N/2-1 since it is exactly LOG2N-1 bits wide
            RUN: if (!halt) begin
                j_nxt = j + JW'(1);
                state_nxt = j == '1 ? DRAIN : RUN;
            end
            // wait for the last write-back of this stage before the next stage reads it
            DRAIN: if (d == DW'(BF_LAT - 1)) begin
                state_nxt = s == SW'(LOG2N - 1) ? DONE : RUN;
                s_nxt = s == SW'(LOG2N - 1) ? s : s + SW'(1);
            end else begin
                d_nxt = d + DW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        rd_valid = state == RUN && !halt;
`ifdef FFT_BITREV_EN
        ld_valid = state == LOAD;
        ld_addr = LOG2N'(bitrev(10'(l), LOG2N));
`endif
    end

    // address of the butterfly that will be presented in the next cycle
    always_comb begin
        span = LOG2N'(1) << s_nxt;
        pos = LOG2N'(j_nxt) & (span - LOG2N'(1));
        grp = LOG2N'(j_nxt) >> s_nxt;
        a_nxt = (grp << (int'(s_nxt) + 1)) | pos;
        b_nxt = a_nxt + span;
        tw_nxt = TW'(pos << (LOG2N - 1 - int'(s_nxt)));
    end

    // loading on the transition into RUN keeps addresses aligned with rd_valid and frozen under halt
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
        end else if (state_nxt == RUN) begin
            addr_a <= a_nxt;
            addr_b <= b_nxt;
            tw_idx <= tw_nxt;
        end
    end

    assign stage = s;

    fft_wb_delay #(.DEPTH(BF_LAT), .AW(LOG2N)) u_wb (
        .clk(clk),
        .clr_n(clr_n),
        .rd_valid(rd_valid),
        .rd_a(addr_a),
        .rd_b(addr_b),
        .wr_valid(wr_valid),
        .wr_a(wr_addr_a),
        .wr_b(wr_addr_b)
    );
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: self-checking bench for fft_seq_ctrl (LOG2N=3, BF_LAT=2) against a schedule-level model
module tb_fft_seq_ctrl;
    localparam int L = 3;
    localparam int B = 2;
    localparam int N = 1 << L;
    localparam int HALF = N / 2;
    localparam int TOT = L * HALF;
`ifdef FFT_BITREV_EN
    localparam int LDN = N;
`else
    localparam int LDN = 0;
`endif

    logic clk = 1'b0;
    logic clr_n, start, halt;
    logic busy, done, rd_valid, wr_valid;
    logic [L-1:0] addr_a, addr_b, wr_addr_a, wr_addr_b;
    logic [L-2:0] tw_idx;
    logic [$clog2(L)-1:0] stage;
`ifdef FFT_BITREV_EN
    logic ld_valid;
    logic [L-1:0] ld_addr;
`endif
    int passed = 0;
    int failed = 0;
    int total = 0;
    typedef struct { bit v; int a; int b; } wb_t;
    wb_t wq[$];

    fft_seq_ctrl #(.LOG2N(L), .BF_LAT(B)) dut (
        .clk(clk),
        .clr_n(clr_n),
        .start(start),
        .halt(halt),
        .busy(busy),
        .done(done),
        .rd_valid(rd_valid),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .tw_idx(tw_idx),
        .stage(stage),
        .wr_valid(wr_valid),
        .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
`ifdef FFT_BITREV_EN
        ,
        .ld_valid(ld_valid),
        .ld_addr(ld_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total += 1;
        assert (obs === exp) passed += 1;
        else begin
            failed += 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < L; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    // One transform. The model is a schedule: butterflies k = 0..TOT-1 in order, a B-cycle gap after
    // every N/2 of them, one issue per non-halted cycle, done after the final gap.
    // hp: random halt percentage; poke: pulse start while busy (t=5) and in the done cycle;
    // h0/hn: forced halt window in cycle numbers relative to the start cycle.
    task automatic xfer(input int hp, input bit poke, input int h0, input int hn);
        int k = 0;
        int gap = 0;
        int t = 0;
        int nh = 0;
        int ld = LDN;
        int s, j, span, pos, ea, eb;
        bit h, run, ev, ed;
        bit fin = 0;
        wb_t w;
        wq.delete();
        repeat (B) wq.push_back('{0, 0, 0});
        @(posedge clk);
        #1;
        start = 1;
        halt = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_done", done, 0);
        wq.push_back('{0, 0, 0});
        w = wq.pop_front();
        chk("idle_wr_valid", wr_valid, w.v);
        while (!fin && t < 2000) begin
            t++;
            @(posedge clk);
            #1;
            h = (t >= h0 && t < h0 + hn) || ($urandom_range(99) < hp);
            ed = gap == 0 && k == TOT && ld == 0;
            run = gap == 0 && k < TOT && ld == 0;
            ev = run && !h;
            halt = h;
            start = poke && (t == 5 || ed);
            @(negedge clk);
            chk("rd_valid", rd_valid, ev);
            chk("done", done, ed);
            chk("busy", busy, 1);
`ifdef FFT_BITREV_EN
            chk("ld_valid", ld_valid, ld > 0);
            if (ld > 0) chk("ld_addr", ld_addr, brev(N - ld));
`endif
            ea = 0;
            eb = 0;
            if (ev) begin
                s = k / HALF;
                j = k % HALF;
                span = 1 << s;
                pos = j % span;
                ea = (j / span) * 2 * span + pos;
                eb = ea + span;
                chk("addr_a", addr_a, ea);
                chk("addr_b", addr_b, eb);
                chk("tw_idx", tw_idx, pos * (1 << (L - 1 - s)));
                chk("stage", stage, s);
            end
            wq.push_back('{ev, ea, eb});
            w = wq.pop_front();
            chk("wr_valid", wr_valid, w.v);
            if (w.v) begin
                chk("wr_addr_a", wr_addr_a, w.a);
                chk("wr_addr_b", wr_addr_b, w.b);
            end
            if (ld > 0) begin
                if (h) nh++;
                else ld--;
            end else if (ev) begin
                k++;
                if (k % HALF == 0) gap = B;
            end else if (gap > 0) gap--;
            else if (run) nh++;
            fin = ed;
        end
        chk("done_seen", fin, 1);
        if (fin) chk("latency", t, L * (HALF + B) + 1 + nh + LDN);
    endtask

    initial begin
        clr_n = 0;
        start = 0;
        halt = 0;
        @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_stage", stage, 0);
        chk("rst_wr_addr_a", wr_addr_a, 0);
        chk("rst_wr_addr_b", wr_addr_b, 0);
        #1;
        clr_n = 1;
        repeat (3) @(posedge clk);
        // plain sequence with start pulses while busy and in the done cycle
        xfer(0, 1, 0, 0);
        // chained start right after done; 3-cycle halt at stage 1, j = 2
        xfer(0, 0, 9 + LDN, 3);
        repeat (4) xfer(30, 0, 0, 0);
        @(posedge clk);
        #1;
        start = 0;
        halt = 0;
        repeat (3) @(posedge clk);
        // abort in cycle 9 of an unhalted transform
        @(posedge clk);
        #1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (8 + LDN) @(posedge clk);
        #1;
        chk("pre_abort_rd_valid", rd_valid, 1);
        chk("pre_abort_addr_a", addr_a, 4);
        chk("pre_abort_addr_b", addr_b, 6);
        chk("pre_abort_stage", stage, 1);
        chk("pre_abort_wr_valid", wr_valid, 1);
        chk("pre_abort_wr_addr_b", wr_addr_b, 2);
        #1;
        clr_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_wr_valid", wr_valid, 0);
        chk("abort_addr_a", addr_a, 0);
        chk("abort_addr_b", addr_b, 0);
        chk("abort_tw_idx", tw_idx, 0);
        chk("abort_stage", stage, 0);
        chk("abort_wr_addr_a", wr_addr_a, 0);
        chk("abort_wr_addr_b", wr_addr_b, 0);
        chk("abort_done", done, 0);
        @(posedge clk);
        #2;
        clr_n = 1;
        repeat (30) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_stays_idle", busy, 0);
        end
        xfer(20, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
